// File: rtl/bcd_counter_display.sv
// Modulo up/down counter with prescaler and synchronous load, driving a
// time-multiplexed, active-low, multi-digit 7-segment display.
module bcd_counter_display #(
  parameter  int NUM_DIGITS = 2,
  parameter  int MODULO     = 60,
  parameter  int PRESCALE   = 4,
  parameter  int SCAN_DIV   = 2,
  localparam int CW         = $clog2(MODULO)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  up_i,
  input  logic                  load_i,
  input  logic [CW-1:0]         load_val_i,
  output logic [CW-1:0]         count_o,
  output logic                  wrap_o,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(MODULO - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_bad_digits
    $error("bcd_counter_display: NUM_DIGITS must be 1..4");
  end
  if (MODULO < 2 || MODULO > 10**NUM_DIGITS) begin : g_bad_modulo
    $error("bcd_counter_display: MODULO must be 2..10**NUM_DIGITS");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("bcd_counter_display: PRESCALE must be >= 1");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan
    $error("bcd_counter_display: SCAN_DIV must be >= 1");
  end

  logic [CW-1:0]         count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         scan_tmr_q, scan_tmr_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  step;

  assign step = en_i && (presc_q == PRESC_MAX);

  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      count_d = (load_val_i > CNT_MAX) ? CNT_MAX : load_val_i;
      presc_d = '0;
    end else if (en_i) begin
      presc_d = step ? '0 : presc_q + 1'b1;
      if (step) begin
        if (up_i) begin
          if (count_q == CNT_MAX) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          if (count_q == '0) begin
            count_d = CNT_MAX;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
    end
  end

  // Scanning free-runs from the clock so the display stays lit while paused.
  always_comb begin
    scan_tmr_d = (scan_tmr_q == SCAN_MAX) ? '0 : scan_tmr_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_tmr_q == SCAN_MAX) begin
      scan_idx_d = (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + 1'b1;
    end
    an_d = ~(AN_ONE << scan_idx_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      presc_q    <= '0;
      scan_tmr_q <= '0;
      scan_idx_q <= '0;
      an_q       <= ~AN_ONE;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      presc_q    <= presc_d;
      scan_tmr_q <= scan_tmr_d;
      scan_idx_q <= scan_idx_d;
      an_q       <= an_d;
    end
  end

  // Unused index slots decode to a blank digit.
  logic [3:0] digit [2**IW];
  for (genvar k = 0; k < 2**IW; k++) begin : g_digit
    if (k < NUM_DIGITS) begin : g_used
      localparam int unsigned POW = 10**k;
      assign digit[k] = 4'((32'(count_q) / POW) % 32'd10);
    end else begin : g_unused
      assign digit[k] = 4'hF;
    end
  end

  logic [3:0] digit_sel;
  logic [6:0] seg;

  assign digit_sel = digit[scan_idx_q];

  always_comb begin
    seg = 7'b1111111;
    case (digit_sel)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;
  assign an_o    = an_q;
  assign seg_o   = seg;

endmodule
